instruction_fetcher: RTL and testbench

INSTRUCTION_FETCHER -- requirements
Module: instruction_fetcher

---
 rtl/instruction_fetcher.sv | 129 ++++++++++++
 tb/tb_instruction_fetcher.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetcher.sv
// Instruction fetch unit: walks the PC through the icache. A hit pushes straight
// into the instruction queue. A miss issues a single memory-controller request,
// then fills the icache and pushes the returned word. Redirects from commit
// replace the PC, and any request still in flight is drained and its data dropped.
module instruction_fetcher #(
   parameter int                ADDR_W   = 32,
   parameter int                INST_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              rdy_in,
   output logic [ADDR_W-1:0] if_to_ic_inst_addr,
   input  logic              ic_to_if_hit,
   input  logic [INST_W-1:0] ic_to_if_hit_inst,
   output logic [INST_W-1:0] if_to_ic_inst,
   output logic              if_to_ic_inst_valid,
   output logic              mc_req,
   output logic [ADDR_W-1:0] mc_addr,
   input  logic              mc_done,
   input  logic [INST_W-1:0] mc_data,
   input  logic              iq_full,
   output logic              iq_valid,
   output logic [INST_W-1:0] iq_inst,
   output logic [ADDR_W-1:0] iq_pc,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc
);

   typedef enum logic [1:0] {FETCH, WAIT_MEM, DISCARD} state_t;

   state_t            state, state_nx;
   logic [ADDR_W-1:0] pc, pc_nx;
   logic              mc_req_nx;
   logic [ADDR_W-1:0] mc_addr_nx;
   logic              iq_valid_nx;
   logic [INST_W-1:0] iq_inst_nx;
   logic [ADDR_W-1:0] iq_pc_nx;
   logic [ADDR_W-1:0] pc_inc;

   // Modulo-2^ADDR_W increment, so the PC wraps from all-ones-minus-3 back to 0.
   assign pc_inc = pc + ADDR_W'(4);

   // The lookup address always tracks the PC. Fill data is passed straight through
   // from memory and strobed only when a returning word is actually kept.
   assign if_to_ic_inst_addr  = pc;
   assign if_to_ic_inst       = mc_data;
   assign if_to_ic_inst_valid = rdy_in && (state == WAIT_MEM) && mc_done && !redirect;

   // State register. Reset is asynchronous and abandons any in-flight request.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state    <= FETCH;
         pc       <= RESET_PC;
         mc_req   <= 1'b0;
         mc_addr  <= '0;
         iq_valid <= 1'b0;
         iq_inst  <= '0;
         iq_pc    <= '0;
      end else begin
         state    <= state_nx;
         pc       <= pc_nx;
         mc_req   <= mc_req_nx;
         mc_addr  <= mc_addr_nx;
         iq_valid <= iq_valid_nx;
         iq_inst  <= iq_inst_nx;
         iq_pc    <= iq_pc_nx;
      end
   end

   // Next-state logic. When rdy_in is low everything holds and the push pulse
   // drops, and an mc_done seen in that cycle is ignored.
   always_comb begin
      state_nx    = state;
      pc_nx       = pc;
      mc_req_nx   = mc_req;
      mc_addr_nx  = mc_addr;
      iq_valid_nx = 1'b0;
      iq_inst_nx  = iq_inst;
      iq_pc_nx    = iq_pc;
      if (rdy_in) begin
         case (state)
            FETCH: begin
               if (redirect) begin
                  pc_nx = redirect_pc;
               end else if (!iq_full) begin
                  if (ic_to_if_hit) begin
                     iq_valid_nx = 1'b1;
                     iq_inst_nx  = ic_to_if_hit_inst;
                     iq_pc_nx    = pc;
                     pc_nx       = pc_inc;
                  end else begin
                     // The free queue slot seen here is reserved for the miss return.
                     mc_req_nx  = 1'b1;
                     mc_addr_nx = pc;
                     state_nx   = WAIT_MEM;
                  end
               end
            end
            WAIT_MEM: begin
               if (mc_done && redirect) begin
                  mc_req_nx = 1'b0;
                  pc_nx     = redirect_pc;
                  state_nx  = FETCH;
               end else if (mc_done) begin
                  iq_valid_nx = 1'b1;
                  iq_inst_nx  = mc_data;
                  iq_pc_nx    = pc;
                  pc_nx       = pc_inc;
                  mc_req_nx   = 1'b0;
                  state_nx    = FETCH;
               end else if (redirect) begin
                  pc_nx    = redirect_pc;
                  state_nx = DISCARD;
               end
            end
            DISCARD: begin
               if (redirect) pc_nx = redirect_pc;
               if (mc_done) begin
                  mc_req_nx = 1'b0;
                  state_nx  = FETCH;
               end
            end
            default: state_nx = FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_fetcher.sv
// Directed bench for instruction_fetcher. The stimulus queues the expected queue
// pushes and icache fills. A negedge monitor pops and compares them whenever the
// DUT strobes iq_valid or if_to_ic_inst_valid.
module tb_instruction_fetcher;

   localparam int ADDR_W = 32;
   localparam int INST_W = 32;

   logic              clk_in = 1'b0;
   logic              rst_in, rdy_in;
   logic [ADDR_W-1:0] if_to_ic_inst_addr;
   logic              ic_to_if_hit;
   logic [INST_W-1:0] ic_to_if_hit_inst;
   logic [INST_W-1:0] if_to_ic_inst;
   logic              if_to_ic_inst_valid;
   logic              mc_req;
   logic [ADDR_W-1:0] mc_addr;
   logic              mc_done;
   logic [INST_W-1:0] mc_data;
   logic              iq_full;
   logic              iq_valid;
   logic [INST_W-1:0] iq_inst;
   logic [ADDR_W-1:0] iq_pc;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_pc;

   int compared   = 0;
   int mismatched = 0;

   logic [63:0] push_q[$];   // {pc, inst}
   logic [63:0] fill_q[$];   // {addr, data}

   instruction_fetcher #(.ADDR_W(ADDR_W), .INST_W(INST_W), .RESET_PC(32'h0)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .if_to_ic_inst_addr(if_to_ic_inst_addr),
      .ic_to_if_hit(ic_to_if_hit), .ic_to_if_hit_inst(ic_to_if_hit_inst),
      .if_to_ic_inst(if_to_ic_inst), .if_to_ic_inst_valid(if_to_ic_inst_valid),
      .mc_req(mc_req), .mc_addr(mc_addr), .mc_done(mc_done), .mc_data(mc_data),
      .iq_full(iq_full), .iq_valid(iq_valid), .iq_inst(iq_inst), .iq_pc(iq_pc),
      .redirect(redirect), .redirect_pc(redirect_pc)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   // Idle: the queue is full and there is no hit, so FETCH holds.
   task automatic idle();
      iq_full = 1'b1; ic_to_if_hit = 1'b0; redirect = 1'b0; mc_done = 1'b0;
   endtask

   task automatic exp_push(input logic [31:0] pc, input logic [31:0] inst);
      push_q.push_back({pc, inst});
   endtask

   // Monitor: every push and fill must match the next queued expectation.
   always @(negedge clk_in) begin
      if (rst_in) begin
         if (iq_valid) begin
            if (push_q.size() == 0) chk("unexpected_push", {iq_pc, iq_inst}, 64'h0);
            else chk("push", {iq_pc, iq_inst}, push_q.pop_front());
         end
         if (if_to_ic_inst_valid) begin
            if (fill_q.size() == 0) chk("unexpected_fill", {if_to_ic_inst_addr, if_to_ic_inst}, 64'h0);
            else chk("fill", {if_to_ic_inst_addr, if_to_ic_inst}, fill_q.pop_front());
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_in = 1'b0; rdy_in = 1'b1; ic_to_if_hit_inst = '0; mc_data = '0; redirect_pc = '0;
      idle();
      #1;
      // Reset values
      chk("rst_pc", if_to_ic_inst_addr, 32'h0);
      chk("rst_mc_req", mc_req, 1'b0);
      chk("rst_mc_addr", mc_addr, 32'h0);
      chk("rst_iq_valid", iq_valid, 1'b0);
      chk("rst_fill_valid", if_to_ic_inst_valid, 1'b0);
      tick(); tick();
      rst_in = 1'b1;
      tick();

      // Three consecutive hits push PCs 0, 4 and 8
      iq_full = 1'b0; ic_to_if_hit = 1'b1;
      for (int k = 0; k < 3; k++) begin
         ic_to_if_hit_inst = 32'hA000_0000 + k;
         chk("hit_lookup", if_to_ic_inst_addr, 32'(4 * k));
         exp_push(32'(4 * k), 32'hA000_0000 + k);
         tick();
      end
      idle(); tick();
      chk("after_hits_pc", if_to_ic_inst_addr, 32'hC);

      // Miss at 0x100 is filled and pushed, and the PC moves to 0x104
      redirect = 1'b1; redirect_pc = 32'h100; tick(); redirect = 1'b0;
      chk("redir_100", if_to_ic_inst_addr, 32'h100);
      iq_full = 1'b0; tick(); iq_full = 1'b1;
      chk("miss_req", mc_req, 1'b1);
      chk("miss_addr", mc_addr, 32'h100);
      tick(); tick(); tick();
      chk("miss_req_held", mc_req, 1'b1);
      mc_done = 1'b1; mc_data = 32'h0050_0093;
      fill_q.push_back({32'h100, 32'h0050_0093});
      exp_push(32'h100, 32'h0050_0093);
      tick(); mc_done = 1'b0;
      chk("miss_req_drop", mc_req, 1'b0);
      chk("miss_next_pc", if_to_ic_inst_addr, 32'h104);

      // A redirect while a miss is outstanding discards the returning data
      iq_full = 1'b0; tick(); iq_full = 1'b1;
      tick();
      redirect = 1'b1; redirect_pc = 32'h200; tick(); redirect = 1'b0;
      chk("discard_req_held", mc_req, 1'b1);
      chk("discard_addr", mc_addr, 32'h104);
      tick();
      mc_done = 1'b1; mc_data = 32'hDEAD_BEEF; tick(); mc_done = 1'b0;
      chk("discard_req_drop", mc_req, 1'b0);
      chk("discard_pc", if_to_ic_inst_addr, 32'h200);

      // Redirect and mc_done in the same cycle drop the data and return to FETCH
      iq_full = 1'b0; tick(); iq_full = 1'b1;
      mc_done = 1'b1; mc_data = 32'hBAD0_0001; redirect = 1'b1; redirect_pc = 32'h300;
      tick(); idle();
      chk("same_req_drop", mc_req, 1'b0);
      chk("same_pc", if_to_ic_inst_addr, 32'h300);
      iq_full = 1'b0; ic_to_if_hit = 1'b1; ic_to_if_hit_inst = 32'h1111_0300;
      exp_push(32'h300, 32'h1111_0300);
      tick(); idle();

      // Redirect beats a hit in FETCH
      redirect = 1'b1; redirect_pc = 32'h40; ic_to_if_hit = 1'b1; iq_full = 1'b0;
      ic_to_if_hit_inst = 32'hBAD0_0002;
      tick(); idle();
      chk("redir_hit_pc", if_to_ic_inst_addr, 32'h40);

      // A full queue stalls a hit, and the push resumes at the same PC
      ic_to_if_hit = 1'b1; ic_to_if_hit_inst = 32'h2222_0040;
      tick(); tick();
      chk("full_hold_pc", if_to_ic_inst_addr, 32'h40);
      iq_full = 1'b0; exp_push(32'h40, 32'h2222_0040);
      tick(); idle();
      chk("full_resume_pc", if_to_ic_inst_addr, 32'h44);

      // rdy_in low freezes a hit stream
      iq_full = 1'b0; ic_to_if_hit = 1'b1; ic_to_if_hit_inst = 32'h3333_0044;
      exp_push(32'h44, 32'h3333_0044);
      tick();
      rdy_in = 1'b0; ic_to_if_hit_inst = 32'h3333_0048;
      for (int k = 0; k < 5; k++) tick();
      chk("rdy_hold_pc", if_to_ic_inst_addr, 32'h48);
      rdy_in = 1'b1; exp_push(32'h48, 32'h3333_0048);
      tick(); idle();
      chk("rdy_resume_pc", if_to_ic_inst_addr, 32'h4C);

      // mc_done while rdy_in is low is ignored, so the request stays outstanding
      iq_full = 1'b0; tick(); iq_full = 1'b1;
      rdy_in = 1'b0; mc_done = 1'b1; mc_data = 32'hBAD0_0003; tick();
      rdy_in = 1'b1; mc_done = 1'b0;
      chk("rdy_done_ignored", mc_req, 1'b1);
      mc_done = 1'b1; mc_data = 32'h4444_004C;
      fill_q.push_back({32'h4C, 32'h4444_004C});
      exp_push(32'h4C, 32'h4444_004C);
      tick(); mc_done = 1'b0;
      chk("rdy_done_pc", if_to_ic_inst_addr, 32'h50);

      // The PC wraps from all-ones-minus-3 to 0
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; tick(); redirect = 1'b0;
      iq_full = 1'b0; ic_to_if_hit = 1'b1; ic_to_if_hit_inst = 32'h5555_FFFC;
      exp_push(32'hFFFF_FFFC, 32'h5555_FFFC);
      tick(); idle();
      chk("wrap_pc", if_to_ic_inst_addr, 32'h0);

      // Reset during WAIT_MEM abandons the request
      redirect = 1'b1; redirect_pc = 32'h80; tick(); redirect = 1'b0;
      iq_full = 1'b0; tick(); iq_full = 1'b1;
      chk("pre_rst_req", mc_req, 1'b1);
      rst_in = 1'b0; #1;
      chk("rst_mid_req", mc_req, 1'b0);
      chk("rst_mid_pc", if_to_ic_inst_addr, 32'h0);
      tick(); rst_in = 1'b1;
      mc_done = 1'b1; mc_data = 32'hBAD0_0004; tick(); mc_done = 1'b0;
      chk("post_rst_req", mc_req, 1'b0);
      tick(); tick();

      chk("push_q_empty", 64'(push_q.size()), 64'h0);
      chk("fill_q_empty", 64'(fill_q.size()), 64'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
